// File: rtl/pu_msp430_watchdog.sv
// Watchdog timer peripheral: password-protected WDTCTL register, a 16-bit
// interval counter advanced by ACLK/SMCLK enable strobes, and the wdtifg,
// NMI-select and PUC-request outputs consumed by the SFR block.
module pu_msp430_watchdog #(
    parameter logic [14:0] BASE_ADDR = 15'h0120,
    parameter logic [7:0]  WDT_PW    = 8'h5A,
    parameter logic [7:0]  WDT_RD_PW = 8'h69
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    input  logic        aclk_en,
    input  logic        smclk_en,
    input  logic        dbg_freeze,
    input  logic        wdtie,
    input  logic        wdtifg_sw_set,
    input  logic        wdtifg_sw_clr,
    input  logic        wdtifg_irq_acc,
    output logic        wdtifg,
    output logic        wdt_irq,
    output logic        wdtnmies,
    output logic        wdtnmi,
    output logic        wdt_reset
);

    // WDTCTL bit positions
    localparam int HOLD  = 7;
    localparam int NMIES = 6;
    localparam int NMI   = 5;
    localparam int TMSEL = 4;
    localparam int CNTCL = 3;
    localparam int SSEL  = 2;

    logic [7:0]  wdtctl_q, wdtctl_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wdtifg_q, wdtifg_d;
    logic        wdt_reset_q, wdt_reset_d;

    logic        reg_sel, reg_wr, reg_rd;
    logic        pw_ok, wr_valid, pw_err;
    logic        tick, terminal, expiry;
    logic [15:0] term_mask;

    // Register decode and password check for the single WDTCTL word
    always_comb begin
        reg_sel  = per_en && (per_addr == BASE_ADDR[14:1]);
        reg_wr   = reg_sel && (per_we != 2'b00);
        reg_rd   = reg_sel && (per_we == 2'b00);
        pw_ok    = (per_din[15:8] == WDT_PW);
        wr_valid = reg_wr && pw_ok;
        pw_err   = reg_wr && !pw_ok;
    end

    // Select the interval: only the low N bits take part in the terminal test
    always_comb begin
        unique case (wdtctl_q[1:0])
            2'b00:   term_mask = 16'h7FFF;
            2'b01:   term_mask = 16'h1FFF;
            2'b10:   term_mask = 16'h01FF;
            default: term_mask = 16'h003F;
        endcase
        tick     = (wdtctl_q[SSEL] ? aclk_en : smclk_en) && !wdtctl_q[HOLD] && !dbg_freeze;
        terminal = ((cnt_q & term_mask) == term_mask);
    end

    // Counter advance; a CNTCL write wins over a coincident tick and its expiry
    always_comb begin
        cnt_d  = cnt_q;
        expiry = 1'b0;
        if (wr_valid && per_din[CNTCL]) begin
            cnt_d = 16'h0000;
        end else if (tick) begin
            if (terminal) begin
                cnt_d  = 16'h0000;
                expiry = 1'b1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Next-state for control register, interrupt flag and PUC request pulse
    always_comb begin
        wdtctl_d = wdtctl_q;
        if (wr_valid) begin
            // CNTCL is a strobe, never stored
            wdtctl_d = {per_din[7:4], 1'b0, per_din[2:0]};
        end

        wdtifg_d = wdtifg_q;
        if (expiry || wdtifg_sw_set) begin
            wdtifg_d = 1'b1;
        end else if (wdtifg_sw_clr) begin
            wdtifg_d = 1'b0;
        end else if (wdtifg_irq_acc && wdtctl_q[TMSEL]) begin
            wdtifg_d = 1'b0;
        end

        // Both causes merge into one single-cycle request
        wdt_reset_d = pw_err || (expiry && !wdtctl_q[TMSEL]);
    end

    // State registers with synchronous reset
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            wdtctl_q    <= 8'h00;
            cnt_q       <= 16'h0000;
            wdtifg_q    <= 1'b0;
            wdt_reset_q <= 1'b0;
        end else begin
            wdtctl_q    <= wdtctl_d;
            cnt_q       <= cnt_d;
            wdtifg_q    <= wdtifg_d;
            wdt_reset_q <= wdt_reset_d;
        end
    end

    // Read mux and outputs
    always_comb begin
        per_dout = 16'h0000;
        if (reg_rd) begin
            per_dout = {WDT_RD_PW, wdtctl_q[7:4], 1'b0, wdtctl_q[2:0]};
        end
        wdtifg    = wdtifg_q;
        wdt_irq   = wdtifg_q && wdtie && wdtctl_q[TMSEL];
        wdtnmies  = wdtctl_q[NMIES];
        wdtnmi    = wdtctl_q[NMI];
        wdt_reset = wdt_reset_q;
    end

endmodule

// File: tb/tb_pu_msp430_watchdog.sv
// Bench for pu_msp430_watchdog: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// behavioural model of the watchdog.
module tb_pu_msp430_watchdog;

    localparam logic [13:0] ADDR = 14'h0090;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic        aclk_en, smclk_en, dbg_freeze;
    logic        wdtie, wdtifg_sw_set, wdtifg_sw_clr, wdtifg_irq_acc;
    logic        wdtifg, wdt_irq, wdtnmies, wdtnmi, wdt_reset;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    logic [7:0] m_ctl = 8'h00;
    int         m_cnt = 0;
    bit         m_ifg = 1'b0;
    bit         m_rst = 1'b0;
    bit         m_valid = 1'b0;
    logic [15:0] e_dout;

    pu_msp430_watchdog dut (
        .mclk(mclk), .puc_rst(puc_rst), .per_addr(per_addr), .per_din(per_din),
        .per_en(per_en), .per_we(per_we), .per_dout(per_dout),
        .aclk_en(aclk_en), .smclk_en(smclk_en), .dbg_freeze(dbg_freeze),
        .wdtie(wdtie), .wdtifg_sw_set(wdtifg_sw_set), .wdtifg_sw_clr(wdtifg_sw_clr),
        .wdtifg_irq_acc(wdtifg_irq_acc), .wdtifg(wdtifg), .wdt_irq(wdt_irq),
        .wdtnmies(wdtnmies), .wdtnmi(wdtnmi), .wdt_reset(wdt_reset)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model of one clock edge, from the register-level rules of the watchdog
    function automatic void model_step();
        int  n, period;
        bit  wr_ok, wr_bad, tick, fire, tm;
        if (puc_rst) begin
            m_ctl = 8'h00; m_cnt = 0; m_ifg = 0; m_rst = 0; m_valid = 1;
            return;
        end
        wr_ok  = per_en && per_addr == ADDR && per_we != 2'b00 && per_din[15:8] == 8'h5A;
        wr_bad = per_en && per_addr == ADDR && per_we != 2'b00 && per_din[15:8] != 8'h5A;
        tick   = (m_ctl[2] ? aclk_en : smclk_en) && !m_ctl[7] && !dbg_freeze;
        case (m_ctl[1:0])
            2'd0: n = 15;
            2'd1: n = 13;
            2'd2: n = 9;
            default: n = 6;
        endcase
        period = 1 << n;
        fire = 0;
        tm = m_ctl[4];
        if (wr_ok && per_din[3]) m_cnt = 0;
        else if (tick) begin
            if (m_cnt % period == period - 1) begin
                fire = 1;
                m_cnt = 0;
            end else m_cnt = (m_cnt + 1) % 65536;
        end
        if (fire || wdtifg_sw_set) m_ifg = 1;
        else if (wdtifg_sw_clr) m_ifg = 0;
        else if (wdtifg_irq_acc && tm) m_ifg = 0;
        m_rst = wr_bad || (fire && !tm);
        if (wr_ok) m_ctl = per_din[7:0] & 8'hF7;
    endfunction

    // Compare process: every falling edge once the model has seen a reset
    always @(negedge mclk) begin
        if (m_valid) begin
            e_dout = (per_en && per_addr == ADDR && per_we == 2'b00) ? {8'h69, m_ctl} : 16'h0000;
            chk("per_dout", per_dout, e_dout);
            chk("wdtifg", {15'd0, wdtifg}, {15'd0, m_ifg});
            chk("wdt_irq", {15'd0, wdt_irq}, {15'd0, m_ifg && wdtie && m_ctl[4]});
            chk("wdtnmies", {15'd0, wdtnmies}, {15'd0, m_ctl[6]});
            chk("wdtnmi", {15'd0, wdtnmi}, {15'd0, m_ctl[5]});
            chk("wdt_reset", {15'd0, wdt_reset}, {15'd0, m_rst});
        end
    end

    task automatic cycle();
        @(posedge mclk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [15:0] d);
        per_en = 1; per_we = 2'b11; per_addr = ADDR; per_din = d;
        cycle();
        per_en = 0; per_we = 2'b00;
    endtask

    task automatic read_chk(input string nm, input logic [15:0] exp);
        per_en = 1; per_we = 2'b00; per_addr = ADDR;
        #1;
        chk(nm, per_dout, exp);
        per_en = 0;
    endtask

    task automatic wait_ifg(input int budget, output int n);
        n = 0;
        while (!wdtifg && n < budget) begin
            cycle();
            n++;
        end
    endtask

    int n, cnt_a, cnt_b, pulses, ev;
    bit prev_ifg;
    logic [7:0] b;

    initial begin
        puc_rst = 1; per_addr = 0; per_din = 0; per_en = 0; per_we = 0;
        aclk_en = 0; smclk_en = 0; dbg_freeze = 0; wdtie = 0;
        wdtifg_sw_set = 0; wdtifg_sw_clr = 0; wdtifg_irq_acc = 0;
        cycle(); cycle();
        puc_rst = 0;

        // 1: reset state and password violation
        chk("rst wdtifg", {15'd0, wdtifg}, 16'd0);
        chk("rst wdt_reset", {15'd0, wdt_reset}, 16'd0);
        chk("rst wdtnmies", {15'd0, wdtnmies}, 16'd0);
        read_chk("rst read", 16'h6900);
        wr(16'h1234);
        chk("pw err pulse", {15'd0, wdt_reset}, 16'd1);
        cycle();
        chk("pw err pulse end", {15'd0, wdt_reset}, 16'd0);
        read_chk("pw err ctl kept", 16'h6900);

        // 2: interval mode, IS=11 on SMCLK
        wdtie = 1;
        wr(16'h5A13);
        smclk_en = 1;
        wait_ifg(200, n);
        chk("interval first rise", n[15:0], 16'd64);
        chk("interval irq", {15'd0, wdt_irq}, 16'd1);
        wdtifg_irq_acc = 1;
        cycle();
        wdtifg_irq_acc = 0;
        chk("irq acc clears", {15'd0, wdtifg}, 16'd0);
        wait_ifg(200, n);
        chk("interval period", 16'(n + 1), 16'd64);

        // 3: watchdog mode expiry, then periodic kicking
        wdtifg_sw_clr = 1;
        wr(16'h5A03);
        wdtifg_sw_clr = 0;
        chk("sw clr", {15'd0, wdtifg}, 16'd0);
        n = 0;
        while (!wdt_reset && n < 200) begin
            cycle();
            n++;
        end
        chk("wdog expiry ticks", 16'(n + 1), 16'd64);
        chk("wdog sets ifg", {15'd0, wdtifg}, 16'd1);
        cycle();
        chk("wdog pulse width", {15'd0, wdt_reset}, 16'd0);
        cnt_a = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i % 50 == 0) wr(16'h5A0B);
            else cycle();
            if (wdt_reset) cnt_a++;
        end
        chk("kicked no reset", cnt_a[15:0], 16'd0);

        // 4: HOLD freezes the count; ACLK source ignores SMCLK
        wdtifg_sw_clr = 1;
        wr(16'h5A97);
        wdtifg_sw_clr = 0;
        cnt_a = 0;
        for (int i = 0; i < 300; i++) begin
            aclk_en = i[0];
            cycle();
            if (wdt_reset || wdtifg) cnt_a++;
        end
        chk("hold no event", cnt_a[15:0], 16'd0);
        wr(16'h5A17);
        pulses = 0; ev = 0; prev_ifg = 0;
        for (int i = 0; i < 3000 && ev < 3; i++) begin
            aclk_en = 1'($urandom_range(0, 1));
            smclk_en = 1'($urandom_range(0, 1));
            wdtifg_sw_clr = wdtifg;
            prev_ifg = wdtifg;
            cycle();
            if (aclk_en) pulses++;
            if (wdtifg && !prev_ifg) begin
                ev++;
                if (ev >= 2) chk("aclk period", pulses[15:0], 16'd64);
                pulses = 0;
            end
        end
        chk("aclk events seen", ev[15:0], 16'd3);
        wdtifg_sw_clr = 0; aclk_en = 0; smclk_en = 0;

        // 5: NMI select bits, expiry beats a same-cycle software clear
        wr(16'h5A40);
        chk("nmies set", {15'd0, wdtnmies}, 16'd1);
        chk("nmi clear", {15'd0, wdtnmi}, 16'd0);
        wdtifg_sw_clr = 1;
        wr(16'h5A4B);
        smclk_en = 1;
        wait_ifg(200, n);
        chk("set beats clr", n[15:0], 16'd64);
        chk("set beats clr reset", {15'd0, wdt_reset}, 16'd1);
        cycle();
        chk("clr after set", {15'd0, wdtifg}, 16'd0);
        wdtifg_sw_clr = 0;

        // 6: reset mid-count discards the count
        smclk_en = 0;
        wr(16'h5A1B);
        smclk_en = 1;
        repeat (40) cycle();
        puc_rst = 1;
        cycle();
        puc_rst = 0; smclk_en = 0;
        chk("midrst wdtifg", {15'd0, wdtifg}, 16'd0);
        chk("midrst irq", {15'd0, wdt_irq}, 16'd0);
        chk("midrst reset", {15'd0, wdt_reset}, 16'd0);
        chk("midrst nmies", {15'd0, wdtnmies}, 16'd0);
        read_chk("midrst read", 16'h6900);
        wr(16'h5A13);
        smclk_en = 1;
        wait_ifg(200, n);
        chk("count restarted", n[15:0], 16'd64);

        // Randomized traffic, model-checked every cycle
        for (int i = 0; i < 4000; i++) begin
            puc_rst        = ($urandom_range(0, 299) == 0);
            per_en         = ($urandom_range(0, 15) == 0);
            per_addr       = ($urandom_range(0, 3) != 0) ? ADDR : 14'($urandom);
            per_we         = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
            b              = 8'($urandom);
            if ($urandom_range(0, 3) != 0) b[7] = 1'b0;
            if ($urandom_range(0, 3) != 0) b[1:0] = 2'b11;
            b[3]           = ($urandom_range(0, 7) == 0);
            per_din        = {(($urandom_range(0, 7) != 0) ? 8'h5A : 8'($urandom)), b};
            aclk_en        = 1'($urandom_range(0, 1));
            smclk_en       = 1'($urandom_range(0, 1));
            dbg_freeze     = ($urandom_range(0, 15) == 0);
            wdtie          = 1'($urandom_range(0, 1));
            wdtifg_sw_set  = ($urandom_range(0, 63) == 0);
            wdtifg_sw_clr  = ($urandom_range(0, 31) == 0);
            wdtifg_irq_acc = ($urandom_range(0, 15) == 0);
            cycle();
        end
        puc_rst = 0; per_en = 0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pu_msp430_watchdog.md
Name: pu_msp430_watchdog

Overview:
Watchdog timer peripheral feeding the SFR block: produces wdtifg, wdtnmies and the watchdog PUC request, and consumes wdtie, wdtifg_sw_set and wdtifg_sw_clr from the SFR.
- Holds the password-protected WDTCTL register on the 16-bit peripheral bus.
- Runs a 16-bit interval counter clocked by ACLK/SMCLK enable strobes in the mclk domain.
- Operates in watchdog (reset) mode or interval-timer (interrupt) mode.

Parameters:
BASE_ADDR, 15'h0120, register base address (WDTCTL at offset 0, word access)
WDT_PW, 8'h5A, write password, checked on per_din[15:8]
WDT_RD_PW, 8'h69, value returned in per_dout[15:8] on read

Ports:
mclk  in  1  main clock; the only clock
puc_rst  in  1  synchronous active-high reset
per_addr  in  14  peripheral word address
per_din  in  16  peripheral write data
per_en  in  1  peripheral enable
per_we  in  2  byte write enables
per_dout  out  16  read data, 0 when not selected
aclk_en  in  1  ACLK tick strobe
smclk_en  in  1  SMCLK tick strobe
dbg_freeze  in  1  halt counter (debug)
wdtie  in  1  interrupt enable from SFR
wdtifg_sw_set  in  1  software set of wdtifg from SFR
wdtifg_sw_clr  in  1  software clear of wdtifg from SFR
wdtifg_irq_acc  in  1  interrupt vector accepted
wdtifg  out  1  interrupt flag, to SFR
wdt_irq  out  1  interval interrupt request
wdtnmies  out  1  NMI edge select, to SFR
wdtnmi  out  1  RST/NMI pin function select
wdt_reset  out  1  PUC request, one-cycle pulse

Behaviour:
Reset and clocking:
- One clock, mclk. puc_rst is synchronous, active-high, with priority over every other event.
- On reset: WDTCTL=8'h00, counter=0, wdtifg=0, wdt_reset=0. wdt_irq, wdtnmi and wdtnmies are therefore 0.
- A reset asserted mid-count discards the count.

Register decode and read:
- Select when per_en=1 and per_addr == BASE_ADDR[14:1].
- Read (per_we==0): per_dout = {WDT_RD_PW, WDTCTL} with bit3 forced to 0. per_dout is combinational, same cycle.

WDTCTL bits:
- [7] HOLD, [6] NMIES, [5] NMI, [4] TMSEL, [3] CNTCL (write-only, self-clearing), [2] SSEL, [1:0] IS.

Writes:
- Any write (per_we != 0) with per_din[15:8]==WDT_PW updates WDTCTL[7:0] from per_din[7:0] at the clock edge.
- Any write with a wrong password leaves WDTCTL unchanged and sets wdt_reset=1 for exactly one cycle after that edge.

Counter:
- tick = (SSEL ? aclk_en : smclk_en) & ~HOLD & ~dbg_freeze.
- Terminal bit N: IS=00 → 15, 01 → 13, 10 → 9, 11 → 6. Period is 2^N ticks.
- On tick: if cnt[N-1:0] is all ones, cnt ← 0 and expiry fires; otherwise cnt ← cnt+1.
- The upper bits are don't-care for expiry. An IS change takes effect on the next tick.
- A valid write with per_din[3]=1 clears cnt to 0 at that edge. It overrides a same-cycle tick and suppresses that cycle's expiry.

Expiry:
- Registered, visible the cycle after the terminal tick edge.
- wdtifg←1 in both modes.
- If TMSEL=0, wdt_reset pulses 1 for one cycle.

wdtifg priority (highest first):
1. expiry or wdtifg_sw_set → 1
2. wdtifg_sw_clr → 0
3. wdtifg_irq_acc with TMSEL=1 → 0

Outputs:
- wdt_irq = wdtifg & wdtie & TMSEL (combinational).
- wdtnmies = NMIES; wdtnmi = NMI.
- wdt_reset is a pulse: cleared the cycle after it asserts.
- A password error and an expiry in the same cycle produce a single one-cycle pulse.

Test Plan:
1. Reset, read BASE_ADDR → per_dout=16'h6900. Write 16'h1234 → next cycle wdt_reset=1 for 1 cycle, WDTCTL still 8'h00.
2. Write 16'h5A13 (TMSEL, IS=11, SMCLK), smclk_en=1 continuously, wdtie=1 → wdtifg and wdt_irq rise 64 mclk after the write. Assert wdtifg_irq_acc → wdtifg=0 next cycle. Next rise is 64 ticks later.
3. Write 16'h5A03 (watchdog mode, IS=11) → wdt_reset pulses after 64 ticks, wdtifg=1. Re-writing 16'h5A0B every 50 ticks → no wdt_reset over 1000 cycles.
4. Write 16'h5A97 (HOLD, ACLK) with aclk_en toggling → counter frozen, no event. Write 16'h5A17 → events every 64 aclk_en pulses. smclk_en pulses are ignored throughout.
5. Write 16'h5A40 → wdtnmies=1, wdtnmi=0. In the same cycle as an expiry, drive wdtifg_sw_clr=1 → wdtifg=1 (set wins).
6. Assert puc_rst while cnt=40 → next cycle all outputs 0, read returns 16'h6900, and the count restarts from 0.
